// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state
// encoding, default operand width and a conditional-negate helper.
package seq_divider_pkg;

    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Two's-complement negate when neg is set. Callers zero-extend their
    // operand into 64 bits and cast the result back to their own width,
    // so the low bits hold the correctly wrapped negation (|-8| = 8 in 4
    // bits when read back as unsigned). With neg = sign bit this is abs().
    function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift {R, Q} left by one, and subtract the
// divisor magnitude from R when it fits, shifting the outcome into Q[0].
module div_step
    import seq_divider_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N:0]   r,
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    output logic [N:0]   r_next,
    output logic [N-1:0] q_next
);

    logic [N+1:0] sh;
    logic [N+1:0] d_ext;
    logic         ge;

    // Shift, compare, conditional subtract.
    always_comb begin
        sh     = {r, q[N-1]};
        d_ext  = {2'b00, d};
        ge     = (sh >= d_ext);
        r_next = (N+1)'(ge ? (sh - d_ext) : sh);
        q_next = {q[N-2:0], ge};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor giving an
// N-bit quotient (truncated toward zero) and N-bit remainder after a fixed
// N+2 cycle latency, with start/busy/done handshake and ovf/dbz flags.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           ovf,
    output logic           dbz
);

    localparam int DW = 2 * N;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST    = CW'(N - 1);
    localparam logic [N-1:0]  HALF    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  HALF_M1 = {1'b0, {(N-1){1'b1}}};

    state_t         state;
    logic [CW-1:0]  cnt;

    // Operands captured at the start edge; intermediate datapath state.
    logic [DW-1:0]  dvd_c;
    logic [N-1:0]   dvs_c;
    logic           sign_q;
    logic           sign_r;
    logic [N-1:0]   mag_dvs;
    logic [N:0]     r;
    logic [N-1:0]   q;
    logic           dbz_i;
    logic           pre_ovf;

    logic [DW-1:0]  mag_dvd_c;
    logic [N-1:0]   mag_dvs_c;
    logic [N:0]     r_nx;
    logic [N-1:0]   q_nx;
    logic [N-1:0]   q_signed;
    logic [N-1:0]   r_signed;
    logic           q_big;
    logic           ovf_c;

    div_step #(.N(N)) u_step (
        .r      (r),
        .q      (q),
        .d      (mag_dvs),
        .r_next (r_nx),
        .q_next (q_nx)
    );

    // Operand magnitudes for PREP and sign/overflow fix-up for FIX.
    always_comb begin
        mag_dvd_c = DW'(cond_neg(64'(dvd_c), dvd_c[DW-1]));
        mag_dvs_c = N'(cond_neg(64'(dvs_c), dvs_c[N-1]));
        q_signed  = N'(cond_neg(64'(q), sign_q));
        r_signed  = N'(cond_neg(64'(r[N-1:0]), sign_r));
        // A negative result may reach -2^(N-1); a positive one only 2^(N-1)-1.
        q_big     = sign_q ? (q > HALF) : (q > HALF_M1);
        ovf_c     = !dbz_i && (pre_ovf || q_big);
    end

    // Datapath registers: capture, magnitude load and iteration; no reset needed.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    dvd_c  <= dividend;
                    dvs_c  <= divisor;
                    sign_q <= dividend[DW-1] ^ divisor[N-1];
                    sign_r <= dividend[DW-1];
                end
            end
            PREP: begin
                mag_dvs <= mag_dvs_c;
                dbz_i   <= (dvs_c == '0);
                // Upper half already >= divisor means the quotient cannot fit.
                pre_ovf <= (mag_dvd_c[DW-1:N] >= mag_dvs_c);
                r       <= {1'b0, mag_dvd_c[DW-1:N]};
                q       <= mag_dvd_c[N-1:0];
            end
            ITER: begin
                r <= r_nx;
                q <= q_nx;
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= PREP;
                        busy  <= 1'b1;
                    end
                end
                PREP: begin
                    state <= ITER;
                    cnt   <= '0;
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    dbz       <= dbz_i;
                    ovf       <= ovf_c;
                    quotient  <= (dbz_i || ovf_c) ? '0 : q_signed;
                    remainder <= (dbz_i || ovf_c) ? '0 : r_signed;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
